// File: rtl/a_bus_pkg.sv
// rtl/a_bus_pkg.sv - shared types and defaults for the A_Bus master arbiter
package a_bus_pkg;
  localparam int A_ADDR_W   = 8;
  localparam int A_DATA_W   = 8;
  localparam int A_MAX_WAIT = 3;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  typedef struct packed {
    logic                we;
    logic [A_ADDR_W-1:0] addr;
    logic [A_DATA_W-1:0] wdata;
  } a_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, scanning from ptr+1 with wrap
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;
  int                pos;

  // Rotating by ptr+1 puts the highest-priority requester at bit 0.
  always_comb begin
    dbl     = {req, req} >> (int'(ptr) + 1);
    rot     = dbl[NREQ-1:0];
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    any_req = |req;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = int'(ptr) + 1 + i;
        if (pos >= NREQ) pos = pos - NREQ;
        idx   = IDX_W'(pos);
        grant = NREQ'(1) << pos;
      end
    end
  end
endmodule

// File: rtl/a_bus_master_arb.sv
// rtl/a_bus_master_arb.sv - arbitrates NREQ requesters onto one A_Bus master port
module a_bus_master_arb
  import a_bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = A_ADDR_W,
  parameter int DATA_W   = A_DATA_W,
  parameter int MAX_WAIT = A_MAX_WAIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          m_req,
  input  logic [NREQ-1:0]          m_we,
  input  logic [NREQ*ADDR_W-1:0]   m_addr,
  input  logic [NREQ*DATA_W-1:0]   m_wdata,
  output logic [NREQ-1:0]          m_done,
  output logic                     m_err,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     bus_req,
  output logic [ADDR_W-1:0]        bus_addr,
  input  logic                     bus_gnt,
  output logic [DATA_W-1:0]        bus_data_o,
  output logic                     bus_data_oe,
  input  logic [DATA_W-1:0]        bus_data_i
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WC_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [NREQ-1:0]    cur_oh;
  logic               cur_we;
  logic [DATA_W-1:0]  cur_wdata;
  logic [WC_W-1:0]    wait_cnt;

  logic [NREQ-1:0]    pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic               pick_we;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_wdata;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req     (m_req),
    .ptr     (ptr),
    .grant   (pick_oh),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    pick_we    = |(m_we & pick_oh);
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_addr  = m_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NREQ - 1);
      cur_idx     <= '0;
      cur_oh      <= '0;
      cur_we      <= 1'b0;
      cur_wdata   <= '0;
      wait_cnt    <= '0;
      m_done      <= '0;
      m_err       <= 1'b0;
      m_rdata     <= '0;
      bus_req     <= 1'b0;
      bus_addr    <= '0;
      bus_data_o  <= '0;
      bus_data_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cur_idx   <= pick_idx;
            cur_oh    <= pick_oh;
            cur_we    <= pick_we;
            cur_wdata <= pick_wdata;
            bus_addr  <= pick_addr;
            wait_cnt  <= '0;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // A grant in the same cycle req first appears is too early to be ours.
          if (bus_gnt && wait_cnt != '0) begin
            bus_req     <= 1'b0;
            bus_data_oe <= cur_we;
            bus_data_o  <= cur_we ? cur_wdata : '0;
            state       <= DATA;
          end else if (wait_cnt == WC_W'(MAX_WAIT)) begin
            bus_req <= 1'b0;
            m_done  <= cur_oh;
            m_err   <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        DATA: begin
          bus_data_oe <= 1'b0;
          bus_data_o  <= '0;
          if (!cur_we) m_rdata <= bus_data_i;
          m_done <= cur_oh;
          m_err  <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          m_done <= '0;
          m_err  <= 1'b0;
          ptr    <= cur_idx;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a_bus_master_arb.sv
// tb/tb_a_bus_master_arb.sv - directed self-checking bench for a_bus_master_arb
module tb_a_bus_master_arb;
  import a_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  m_req;
  logic [3:0]  m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_done;
  logic        m_err;
  logic [7:0]  m_rdata;
  logic        bus_req;
  logic [7:0]  bus_addr;
  logic        bus_gnt;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe;
  logic [7:0]  bus_data_i;

  int tests = 0;
  int fails = 0;

  a_bus_master_arb #(.NREQ(4), .ADDR_W(8), .DATA_W(8), .MAX_WAIT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_done      (m_done),
    .m_err       (m_err),
    .m_rdata     (m_rdata),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_gnt     (bus_gnt),
    .bus_data_o  (bus_data_o),
    .bus_data_oe (bus_data_oe),
    .bus_data_i  (bus_data_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input a_req_t r);
    m_we[i]            = r.we;
    m_addr[i*8 +: 8]   = r.addr;
    m_wdata[i*8 +: 8]  = r.wdata;
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    bus_gnt = 1'b0; bus_data_i = '0;
    tick(); tick();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_m_done", m_done, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_oe", bus_data_oe, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_addr", bus_addr, 0);
    rst = 1'b0;
    tick();
    chk("idle_bus_req", bus_req, 0);

    // 1: write from requester 2, grant at wait_cnt 2
    set_slot(2, '{we: 1'b1, addr: 8'h5A, wdata: 8'hC3});
    m_req = 4'b0100;
    tick();
    chk("t1_req_r0", bus_req, 1);
    chk("t1_addr_r0", bus_addr, 8'h5A);
    tick();
    chk("t1_req_r1", bus_req, 1);
    tick();
    chk("t1_addr_r2", bus_addr, 8'h5A);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("t1_data_req", bus_req, 0);
    chk("t1_data_oe", bus_data_oe, 1);
    chk("t1_data_o", bus_data_o, 8'hC3);
    chk("t1_data_addr", bus_addr, 8'h5A);
    chk("t1_data_nodone", m_done, 0);
    tick();
    chk("t1_done", m_done, 4'b0100);
    chk("t1_err", m_err, 0);
    chk("t1_done_oe", bus_data_oe, 0);
    m_req = '0;
    tick();
    chk("t1_done_clr", m_done, 0);

    // 2: read from requester 0, grant at wait_cnt 1
    set_slot(0, '{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    m_req = 4'b0001;
    tick();
    chk("t2_addr", bus_addr, 8'h10);
    chk("t2_oe_r0", bus_data_oe, 0);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("t2_data_req", bus_req, 0);
    chk("t2_data_oe", bus_data_oe, 0);
    bus_data_i = 8'h7E;
    tick();
    bus_data_i = 8'h00;
    chk("t2_done", m_done, 4'b0001);
    chk("t2_rdata", m_rdata, 8'h7E);
    chk("t2_err", m_err, 0);
    m_req = '0;
    tick();

    // 3a: timeout for requester 1 while requester 3 waits
    set_slot(1, '{we: 1'b1, addr: 8'h21, wdata: 8'h11});
    set_slot(3, '{we: 1'b0, addr: 8'h33, wdata: 8'h00});
    m_req = 4'b1010;
    tick(); chk("t3_req_r0", bus_req, 1);
    chk("t3_addr1", bus_addr, 8'h21);
    tick(); chk("t3_req_r1", bus_req, 1);
    tick(); chk("t3_req_r2", bus_req, 1);
    tick(); chk("t3_req_r3", bus_req, 1);
    tick();
    chk("t3_req_drop", bus_req, 0);
    chk("t3_done", m_done, 4'b0010);
    chk("t3_err", m_err, 1);
    chk("t3_rdata_kept", m_rdata, 8'h7E);
    m_req = 4'b1000;
    tick();
    chk("t3_idle", bus_req, 0);
    // 3b: requester 3 next, with a too-early grant only
    tick();
    chk("t3b_addr3", bus_addr, 8'h33);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("t3b_req_r1", bus_req, 1);
    chk("t3b_oe", bus_data_oe, 0);
    tick(); tick();
    chk("t3b_req_r3", bus_req, 1);
    tick();
    chk("t3b_done", m_done, 4'b1000);
    chk("t3b_err", m_err, 1);
    m_req = '0;
    tick();

    // 4: fairness, all requesting reads, grant at wait_cnt 1
    for (int i = 0; i < 4; i++) set_slot(i, '{we: 1'b0, addr: 8'(8'h40 + i), wdata: 8'h00});
    m_req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("t4_req", bus_req, 1);
      chk("t4_addr", bus_addr, 32'h40 + (t % 4));
      tick();
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0;
      bus_data_i = 8'(8'hA0 + t);
      tick();
      chk("t4_done_order", m_done, 32'h1 << (t % 4));
      chk("t4_rdata", m_rdata, 32'hA0 + t);
      tick();
      chk("t4_idle_gap", bus_req, 0);
    end
    m_req = '0;
    bus_data_i = '0;
    tick();

    // 5a: late grant at wait_cnt 3; drop and data change after latch are ignored
    set_slot(2, '{we: 1'b1, addr: 8'h77, wdata: 8'h3C});
    m_req = 4'b0100;
    tick();
    chk("t5_addr", bus_addr, 8'h77);
    m_req = '0;
    m_wdata[23:16] = 8'hFF;
    m_addr[23:16] = 8'h00;
    tick(); tick(); tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("t5_data_oe", bus_data_oe, 1);
    chk("t5_data_o", bus_data_o, 8'h3C);
    chk("t5_data_addr", bus_addr, 8'h77);
    tick();
    chk("t5_done", m_done, 4'b0100);
    chk("t5_err", m_err, 0);
    tick();
    // 5b: grant one cycle too late
    set_slot(2, '{we: 1'b1, addr: 8'h78, wdata: 8'h5C});
    m_req = 4'b0100;
    tick(); tick(); tick(); tick();
    chk("t5b_req_r3", bus_req, 1);
    tick();
    chk("t5b_done", m_done, 4'b0100);
    chk("t5b_err", m_err, 1);
    chk("t5b_oe", bus_data_oe, 0);
    m_req = '0;
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("t5b_no_data", bus_data_oe, 0);
    chk("t5b_idle_req", bus_req, 0);
    chk("t5b_done_clr", m_done, 0);
    tick();
    chk("t5b_stay_idle", bus_req, 0);

    // 6: reset during REQ, then pointer restarts at requester 0
    set_slot(0, '{we: 1'b0, addr: 8'h01, wdata: 8'h00});
    set_slot(1, '{we: 1'b0, addr: 8'h02, wdata: 8'h00});
    m_req = 4'b0010;
    tick();
    chk("t6_addr1", bus_addr, 8'h02);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_req", bus_req, 0);
    chk("t6_rst_done", m_done, 0);
    m_req = 4'b0011;
    tick();
    chk("t6_req0", bus_req, 1);
    chk("t6_addr0", bus_addr, 8'h01);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();
    chk("t6_done0", m_done, 4'b0001);
    m_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
